// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_arbiter : round-robin IFU/LSU arbiter for the single pmem data port.
// Rev 1.0     : initial release
// ============================================================================
module mem_arbiter #(
    parameter int LAT   = 2,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_wr,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [31:0] lsu_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_wait   = 2'd1;
    localparam logic [1:0] c_access = 2'd2;
    localparam logic [1:0] c_resp   = 2'd3;

    localparam logic [1:0]       c_after_req = (LAT > 0) ? c_wait : c_access;
    localparam logic [CNT_W-1:0] c_lat       = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_id;      // owner of the transaction: 1 = LSU
    logic             r_last;    // last granted requester: 1 = LSU
    logic             r_wr;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;
    logic [31:0]      r_rdata;
    logic             w_gnt_lsu;
    logic             w_resp_hs;

    // On contention the requester that did not win last time gets the port.
    assign w_gnt_lsu = lsu_req_valid && (!ifu_req_valid || !r_last);
    assign w_resp_hs = (r_state == c_resp) && (r_id ? lsu_resp_ready : ifu_resp_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:   if (ifu_req_ready || lsu_req_ready) w_next = c_after_req;
            c_wait:   if (r_cnt == c_one) w_next = c_access;
            c_access: w_next = c_resp;
            c_resp:   if (w_resp_hs) w_next = c_idle;
            default:  w_next = c_idle;
        endcase
    end

    always_comb begin
        ifu_req_ready  = (r_state == c_idle) && ifu_req_valid && !w_gnt_lsu;
        lsu_req_ready  = (r_state == c_idle) && w_gnt_lsu;
        ifu_resp_valid = (r_state == c_resp) && !r_id;
        lsu_resp_valid = (r_state == c_resp) && r_id;
        mem_en         = (r_state == c_access);
        mem_wr         = r_wr;
        mem_addr       = r_addr;
        mem_wdata      = r_wdata;
        mem_wstrb      = r_wstrb;
        ifu_rdata      = r_rdata;
        lsu_rdata      = r_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
        end else begin
            if (ifu_req_ready) begin
                r_id    <= 1'b0;
                r_last  <= 1'b0;
                r_wr    <= 1'b0;
                r_addr  <= ifu_addr;
                r_wdata <= '0;
                r_wstrb <= '0;
                r_cnt   <= c_lat;
            end else if (lsu_req_ready) begin
                r_id    <= 1'b1;
                r_last  <= 1'b1;
                r_wr    <= lsu_wr;
                r_addr  <= lsu_addr;
                r_wdata <= lsu_wdata;
                r_wstrb <= lsu_wstrb;
                r_cnt   <= c_lat;
            end
            if (r_state == c_wait) begin
                r_cnt <= r_cnt - c_one;
            end
            // Captured for writes too, so the ack carries the access result.
            if (r_state == c_access) begin
                r_rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data-memory port (DPI-backed pmem read/write, combinational rdata) between the instruction-fetch unit (IFU) and the load/store unit (LSU) of the NPC core.
- Accepts one request at a time using valid/ready handshakes and round-robin arbitration.
- Inserts a programmable access latency and returns the response through a held valid/ready response channel.
- Guarantees the memory port is enabled for exactly one cycle per transaction, so each pmem_read/pmem_write is issued once per transaction.

Parameters:
LAT, 2, wait cycles between request acceptance and the memory access cycle (0..15)
CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > LAT

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  in  1  IFU read request valid
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  32  IFU fetch address
ifu_resp_valid  out  1  IFU response valid
ifu_resp_ready  in  1  IFU can take response
ifu_rdata  out  32  IFU read data
lsu_req_valid  in  1  LSU request valid
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_wr  in  1  1=write, 0=read
lsu_addr  in  32  LSU address
lsu_wdata  in  32  LSU write data
lsu_wstrb  in  4  LSU byte write mask
lsu_resp_valid  out  1  LSU response valid (read data or write ack)
lsu_resp_ready  in  1  LSU can take response
lsu_rdata  out  32  LSU read data
mem_en  out  1  memory port enable
mem_wr  out  1  memory write select
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_wstrb  out  4  memory byte mask
mem_rdata  in  32  memory data, combinational from mem_en/mem_addr

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0, latched request regs 0, resp data reg 0, last_grant=LSU. Any in-flight transaction is dropped; mem_en falls immediately and asynchronously.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: grant is combinational.
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to last_grant wins.
  - ready is asserted only to the granted requester and only in IDLE.
  - On handshake: latch id, addr, wr, wdata, wstrb (IFU: wr=0, wstrb=0); update last_grant; cnt<=LAT.
  - Next state: WAIT if LAT>0, else ACCESS.
- WAIT: cnt decrements each cycle; when cnt==1, next state is ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_en=1; mem_wr/addr/wdata/wstrb driven from latched regs.
  - mem_rdata is captured into the resp data reg at the closing edge (captured for writes too).
  - Next state: RESP.
- mem_en=0 in every other state. mem_addr/wdata/wstrb/wr always reflect the latched regs, so they are stable throughout the transaction.
- RESP:
  - resp_valid=1 only toward the latched id; held stable until the matching resp_ready=1.
  - On resp handshake, next state is IDLE. A new request can be accepted no earlier than the following cycle.
  - resp_ready from the non-owning requester is ignored.
- Timing for a request handshake in cycle N: mem_en high in cycle N+1+LAT; resp_valid first high in cycle N+2+LAT. Minimum occupancy is 3 cycles (LAT=0) with resp_ready tied high.
- ifu_rdata and lsu_rdata are both driven from the resp data reg. Each is meaningful only with its own resp_valid.
- Requesters must hold valid and payload until ready. A withdrawn unaccepted request has no effect and does not change last_grant.
- No address checking or alignment: addresses are passed unchanged.
- LSU write: response is an ack; lsu_rdata equals the value returned by the write access.

Test Plan:
- Reset, LAT=2, IFU read 0x80000000 (mem returns 0x00000413) in cycle 5 -> ifu_req_ready=1 in cycle 5; mem_en=1 only in cycle 8; ifu_resp_valid=1 from cycle 9 with ifu_rdata=0x00000413; lsu_resp_valid stays 0.
- IFU and LSU both valid in the same IDLE cycle after reset -> IFU granted first. The LSU request, held valid, is granted at the next IDLE. Alternation IFU,LSU,IFU,LSU continues over 4 back-to-back contended requests.
- LSU write addr 0x80001000, wdata 0xDEADBEEF, wstrb 0x3 -> exactly one cycle with mem_en=1, mem_wr=1, mem_wstrb=0x3; lsu_resp_valid asserted as ack.
- Response backpressure: lsu_resp_ready=0 for 5 cycles, IFU valid throughout -> lsu_resp_valid and lsu_rdata held stable; ifu_req_ready=0 and mem_en=0 throughout; IFU granted the cycle after the LSU resp handshake.
- LAT=0 -> request-to-mem_en is 1 cycle and request-to-resp_valid is 2 cycles. Assert rst_n=0 during WAIT (LAT=5) -> mem_en never pulses; all outputs 0 immediately; after release, a new request is served normally with IFU priority.
